// File: rtl/seq_match_logger.sv
// Timestamped match logger: captures the free-running ts on each det pulse
// into a first-word-fall-through FIFO, with match and drop counters.
module seq_match_logger #(
  parameter int TS_W   = 16,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       det,
  input  logic                       clr,
  output logic [TS_W-1:0]            rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [15:0]                match_cnt,
  output logic [DROP_W-1:0]          drop_cnt,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic            pop;
  logic            push;
  logic            wipe;

  assign wipe     = rst | clr;
  assign rd_valid = (level != '0);
  assign full     = (level == LW'(DEPTH));
  assign rd_data  = mem[rp];
  assign pop      = rd_valid & rd_ready;
  assign push     = det & (~full | pop);

  // Storage is never cleared; only pointers and level are.
  always_ff @(posedge clk) begin
    if (!wipe && push) begin
      mem[wp] <= ts;
    end
  end

  always_ff @(posedge clk) begin
    if (wipe) begin
      ts        <= '0;
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
      match_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (det) begin
        match_cnt <= match_cnt + 1'b1;
      end
      if (det && full && !pop && drop_cnt != '1) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_match_logger.sv
// Directed bench for seq_match_logger with a queue-based reference model.
module tb_seq_match_logger;

  localparam int TS_W   = 4;
  localparam int DEPTH  = 8;
  localparam int DROP_W = 2;

  logic              clk = 0;
  logic              rst = 1;
  logic              det = 0;
  logic              clr = 0;
  logic              rd_ready = 0;
  logic [TS_W-1:0]   rd_data;
  logic              rd_valid;
  logic [15:0]       match_cnt;
  logic [DROP_W-1:0] drop_cnt;
  logic [3:0]        level;
  logic              full;

  seq_match_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .det(det), .clr(clr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .match_cnt(match_cnt), .drop_cnt(drop_cnt),
    .level(level), .full(full)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int m_ts = 0;
  int m_match = 0;
  int m_drop = 0;
  int q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input bit d, input bit r, input bit c,
                            input bit rs);
    int sz;
    bit pp;
    if (rs || c) begin
      m_ts = 0;
      m_match = 0;
      m_drop = 0;
      q.delete();
    end else begin
      sz = q.size();
      pp = (sz > 0) && r;
      if (pp) void'(q.pop_front());
      if (d) begin
        m_match = (m_match + 1) % 65536;
        if (sz < DEPTH || pp) q.push_back(m_ts);
        else if (m_drop < (1 << DROP_W) - 1) m_drop++;
      end
      m_ts = (m_ts + 1) % (1 << TS_W);
    end
  endtask

  task automatic step(input bit d, input bit r,
                      input bit c = 0, input bit rs = 0);
    det = d;
    rd_ready = r;
    clr = c;
    rst = rs;
    model_edge(d, r, c, rs);
    @(posedge clk);
    #1;
    chk("rd_valid", int'(rd_valid), int'(q.size() != 0));
    chk("level", int'(level), q.size());
    chk("full", int'(full), int'(q.size() == DEPTH));
    chk("match_cnt", int'(match_cnt), m_match);
    chk("drop_cnt", int'(drop_cnt), m_drop);
    if (q.size() != 0) chk("rd_data", int'(rd_data), q[0]);
  endtask

  logic [TS_W-1:0] held;

  initial begin
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("lit_reset_valid", int'(rd_valid), 0);
    chk("lit_reset_level", int'(level), 0);

    // single match at ts=4
    for (int i = 0; i < 4; i++) step(0, 0);
    step(1, 0);
    chk("lit_single_valid", int'(rd_valid), 1);
    chk("lit_single_data", int'(rd_data), 4);
    chk("lit_single_match", int'(match_cnt), 1);
    step(0, 1);
    chk("lit_single_popped", int'(rd_valid), 0);

    // pop when empty
    step(0, 1);
    step(0, 1);

    // overflow
    step(0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 0);
    chk("lit_ovf_level", int'(level), 8);
    chk("lit_ovf_full", int'(full), 1);
    chk("lit_ovf_match", int'(match_cnt), 10);
    chk("lit_ovf_drop", int'(drop_cnt), 2);
    chk("lit_ovf_head", int'(rd_data), 0);

    // full with simultaneous push and pop
    step(1, 1);
    chk("lit_fullpp_level", int'(level), 8);
    chk("lit_fullpp_drop", int'(drop_cnt), 2);
    chk("lit_fullpp_head", int'(rd_data), 1);
    for (int i = 0; i < 8; i++) step(0, 1);

    // drop counter saturation
    for (int i = 0; i < 11; i++) step(1, 0);
    chk("lit_drop_sat", int'(drop_cnt), 3);
    for (int i = 0; i < 8; i++) step(0, 1);

    // backpressure hold
    step(0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0);
    for (int i = 0; i < 8; i++) begin
      held = rd_data;
      step(0, i % 2);
      if (i % 2 == 0) chk("lit_bp_hold", int'(rd_data), int'(held));
    end
    chk("lit_bp_empty", int'(rd_valid), 0);

    // timestamp wrap
    step(0, 0, 1);
    for (int i = 0; i < 15; i++) step(0, 0);
    step(1, 0);
    step(0, 0);
    step(1, 0);
    chk("lit_wrap_first", int'(rd_data), 15);
    step(0, 1);
    chk("lit_wrap_second", int'(rd_data), 1);
    step(0, 1);

    // pointer wrap: 20 single push/pop pairs
    for (int i = 0; i < 20; i++) begin
      step(1, 0);
      step(0, 1);
    end

    // clr versus det
    for (int i = 0; i < 3; i++) step(1, 0);
    step(1, 0, 1);
    chk("lit_clr_level", int'(level), 0);
    chk("lit_clr_match", int'(match_cnt), 0);
    chk("lit_clr_valid", int'(rd_valid), 0);
    step(1, 0);
    chk("lit_clr_ts0", int'(rd_data), 0);

    // reset mid-operation
    for (int i = 0; i < 4; i++) step(1, 1);
    step(1, 1, 1, 1);
    step(0, 0);
    step(1, 0);
    chk("lit_rst_ts", int'(rd_data), 1);
    step(0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
